// File: rtl/edsac_ctrl_pkg.sv
// rtl/edsac_ctrl_pkg.sv - shared control-section types and constants
package edsac_ctrl_pkg;

  // Default width of the order address field O1..O10
  localparam int ORDER_W_DEF = 10;

  // Pulse intervals per minor cycle, used by benches to pace ev_d0
  localparam int MINOR_CYCLE_PI = 18;

  // Shift sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARM   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_FIN   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/lsb_encoder.sv
// rtl/lsb_encoder.sv - lowest-set-bit priority encoder (index+1 and zero flag)
module lsb_encoder
  import edsac_ctrl_pkg::*;
#(
  parameter int ORDER_W = ORDER_W_DEF,
  parameter int CNT_W   = 4
) (
  input  logic [ORDER_W-1:0] bits,
  output logic [CNT_W-1:0]   idx_p1,
  output logic               zero
);

  // Scan from the top down so the lowest set bit is the last one written
  always_comb begin
    idx_p1 = '0;
    for (int i = ORDER_W - 1; i >= 0; i--) begin
      if (bits[i]) idx_p1 = CNT_W'(i + 1);
    end
  end

  assign zero = ~|bits;

endmodule

// File: rtl/shift_sequencer.sv
// rtl/shift_sequencer.sv - R/L shift order sequencer; optional EDSAC_LONG_SHIFT_EN adds long_op and multi-cycle steps
module shift_sequencer
  import edsac_ctrl_pkg::*;
#(
  parameter int ORDER_W     = ORDER_W_DEF,
  parameter int CNT_W       = 4,
  parameter int LONG_CYCLES = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               dir_left,
  input  logic [ORDER_W-1:0] order_addr,
  input  logic               ev_d0,
`ifdef EDSAC_LONG_SHIFT_EN
  input  logic               long_op,
`endif
  output logic               g_left,
  output logic               g_right,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ARM   = ST_ARM;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_FIN   = ST_FIN;

  // The step counter must be able to hold the highest index+1
  if ((2 ** CNT_W) <= ORDER_W || LONG_CYCLES < 1) begin : g_bad_cfg
    $error("shift_sequencer: illegal CNT_W/ORDER_W/LONG_CYCLES combination");
  end

  logic [1:0]       state;
  logic [CNT_W-1:0] steps;
  logic             dir_r;
  logic [CNT_W-1:0] enc_idx;
  logic             enc_zero;
  logic             mc_zero;

  lsb_encoder #(
    .ORDER_W (ORDER_W),
    .CNT_W   (CNT_W)
  ) u_enc (
    .bits   (order_addr),
    .idx_p1 (enc_idx),
    .zero   (enc_zero)
  );

`ifdef EDSAC_LONG_SHIFT_EN
  localparam int MC_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;

  logic            long_r;
  logic [MC_W-1:0] mc;
  logic [MC_W-1:0] mc_reload;

  assign mc_reload = long_r ? MC_W'(LONG_CYCLES - 1) : '0;
  assign mc_zero   = (mc == '0);

  // Minor-cycle counter: counts ev_d0 marks within one single-digit step
  always_ff @(posedge clk) begin
    if (reset) begin
      long_r <= 1'b0;
      mc     <= '0;
    end else begin
      if (state == S_IDLE && start) long_r <= long_op;
      if (state == S_ARM && ev_d0) begin
        mc <= mc_reload;
      end else if (state == S_SHIFT && ev_d0) begin
        mc <= mc_zero ? mc_reload : mc - 1'b1;
      end
    end
  end
`else
  // One minor cycle per step: every mark in SHIFT ends a step
  assign mc_zero = 1'b1;
`endif

  // Main sequencer: order acceptance, gate windows and termination pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      steps   <= '0;
      dir_r   <= 1'b0;
      g_left  <= 1'b0;
      g_right <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            dir_r <= dir_left;
            steps <= enc_idx;
            busy  <= 1'b1;
            state <= enc_zero ? S_FIN : S_ARM;
          end
        end
        S_ARM: begin
          if (ev_d0) begin
            state   <= S_SHIFT;
            g_left  <= dir_r;
            g_right <= ~dir_r;
          end
        end
        S_SHIFT: begin
          if (ev_d0 && mc_zero) begin
            if (steps == CNT_W'(1)) begin
              state   <= S_FIN;
              g_left  <= 1'b0;
              g_right <= 1'b0;
              done    <= 1'b1;
            end else begin
              steps <= steps - 1'b1;
            end
          end
        end
        S_FIN: begin
          // Shift path arrives with done already set; a zero-field order
          // spends one extra cycle here so done lands two clocks after start.
          if (!done) begin
            done <= 1'b1;
          end else begin
            done  <= 1'b0;
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// tb/tb_shift_sequencer.sv - self-checking bench for shift_sequencer
module tb_shift_sequencer;
  import edsac_ctrl_pkg::*;

  localparam int OW = 10;
  localparam int CW = 4;
  localparam int LC = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          dir_left = 1'b0;
  logic [OW-1:0] order_addr = '0;
  logic          ev_d0 = 1'b0;
  logic          long_op = 1'b0;
  logic          g_left, g_right, busy, done;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  shift_sequencer #(
    .ORDER_W     (OW),
    .CNT_W       (CW),
    .LONG_CYCLES (LC)
  ) dut (
`ifdef EDSAC_LONG_SHIFT_EN
    .long_op    (long_op),
`endif
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .dir_left   (dir_left),
    .order_addr (order_addr),
    .ev_d0      (ev_d0),
    .g_left     (g_left),
    .g_right    (g_right),
    .busy       (busy),
    .done       (done)
  );

  task automatic check(input string tag, input int cyc, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    assert (obs === exp_v) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  // Timeline model: cycle 0 carries start; ev_d0 fires when cyc % period == phase.
  // Outputs observed in cycle o are what the edge ending cycle o-1 produced.
  task automatic run_case(input string tag, input logic dir, input logic [OW-1:0] addr,
                          input logic lng, input int period, input int phase,
                          input int restart_at, input int reset_at);
    int n, c, e, cnt, rise, fall, done_c, limit, o, gate_cnt;
    logic gate_on;
    logic [3:0] exp_v, obs_v;
    n = 0;
    for (int i = OW - 1; i >= 0; i--) if (addr[i]) n = i + 1;
`ifdef EDSAC_LONG_SHIFT_EN
    c = lng ? LC : 1;
`else
    c = 1;
`endif
    rise = -1;
    fall = -1;
    if (n == 0) begin
      done_c = 2;
    end else begin
      cnt = 0;
      e = 0;
      while (cnt < n * c + 1) begin
        e++;
        if (e % period == phase) begin
          cnt++;
          if (cnt == 1) rise = e + 1;
        end
      end
      fall = e + 1;
      done_c = fall;
    end
    limit = (reset_at >= 0) ? reset_at + 4 : done_c + 3;
    gate_cnt = 0;
    for (int cyc = 0; cyc < limit; cyc++) begin
      start      = (cyc == 0) || (cyc == restart_at);
      dir_left   = (cyc == 0) ? dir : ~dir;
      order_addr = (cyc == 0) ? addr : OW'($urandom);
      long_op    = (cyc == 0) ? lng : ~lng;
      ev_d0      = (cyc % period == phase);
      reset      = (cyc == reset_at);
      @(posedge clk);
      #1;
      o = cyc + 1;
      gate_on = (rise >= 0) && (o >= rise) && (o < fall);
      exp_v = {gate_on & dir, gate_on & ~dir, (o >= 1) && (o <= done_c), o == done_c};
      if (reset_at >= 0 && o > reset_at) exp_v = 4'b0000;
      obs_v = {g_left, g_right, busy, done};
      if (g_left | g_right) gate_cnt++;
      check(tag, o, 32'(obs_v), 32'(exp_v));
    end
    start = 1'b0;
    ev_d0 = 1'b0;
    reset = 1'b0;
    if (reset_at < 0) check({tag, "_gate_len"}, limit, 32'(gate_cnt), 32'(n * c * period));
  endtask

  initial begin
    logic          rdir, rlng;
    logic [OW-1:0] raddr;
    int            rp, rph, rrs;

    // Reset state
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      check("reset_state", k, 32'({g_left, g_right, busy, done}), 32'h0);
    end
    reset = 1'b0;

    run_case("r_o3",        1'b0, 10'b0000000100, 1'b0, MINOR_CYCLE_PI, 5, -1, -1);
    run_case("l_o10",       1'b1, 10'b1000000000, 1'b0, MINOR_CYCLE_PI, 7, -1, -1);
    run_case("zero_field",  1'b0, 10'b0000000000, 1'b0, MINOR_CYCLE_PI, 4,  1, -1);
    run_case("coincident",  1'b0, 10'b0000000001, 1'b0, MINOR_CYCLE_PI, 0, -1, -1);
    run_case("busy_ignore", 1'b1, 10'b0000010110, 1'b0, 5, 2, 7, -1);
    run_case("mid_reset",   1'b0, 10'b0000001000, 1'b0, MINOR_CYCLE_PI, 2, -1, 5);
    run_case("after_reset", 1'b1, 10'b0000001000, 1'b0, 6, 3, -1, -1);
`ifdef EDSAC_LONG_SHIFT_EN
    run_case("long_o2",     1'b0, 10'b0000000010, 1'b1, MINOR_CYCLE_PI, 9, -1, -1);
    run_case("short_o2",    1'b1, 10'b0000000010, 1'b0, MINOR_CYCLE_PI, 9, -1, -1);
`endif

    for (int t = 0; t < 16; t++) begin
      rdir  = 1'($urandom);
      rlng  = 1'($urandom);
      raddr = OW'($urandom);
      if ($urandom_range(0, 3) == 0) raddr = OW'(1) << $urandom_range(0, OW - 1);
      rp  = $urandom_range(2, 20);
      rph = $urandom_range(0, rp - 1);
      rrs = (raddr != 0) ? $urandom_range(1, rp) : -1;
      run_case("random", rdir, raddr, rlng, rp, rph, rrs, -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
